// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the SRAM controller:
// FSM states, access op codes, default parameters, half selects.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
  localparam int DEF_WAIT_CYCLES = 1;
  localparam int DEF_ADDR_W = 18;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage <-> SRAM controller request bus.
// master: rd_en, wr_en, addr, wr_data out; rd_data, ready in.
interface sram_controller_if;

  logic        rd_en;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ready;

  modport master (
    output rd_en,
    output wr_en,
    output addr,
    output wr_data,
    input  rd_data,
    input  ready
  );

  modport slave (
    input  rd_en,
    input  wr_en,
    input  addr,
    input  wr_data,
    output rd_data,
    output ready
  );

endinterface

// File: rtl/sram_controller_rd_cache.sv
// One-entry read cache: valid, word-index tag, 32-bit data.
// Ports: look_tag/hit/hit_data lookup; fill, upd, wr_tag, wr_word.
module sram_rd_cache
  import sram_ctrl_pkg::*;
#(
  parameter int TAG_W = DEF_ADDR_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] look_tag,
  output logic             hit,
  output logic [31:0]      hit_data,
  input  logic             fill,
  input  logic             upd,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_word
);

  logic             valid;
  logic [TAG_W-1:0] tag;
  logic [31:0]      data;

  assign hit      = valid && (tag == look_tag);
  assign hit_data = data;

  // fill: read miss completed; upd: write-through,
  // only touches the entry when it holds that word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      data  <= wr_word;
    end else if (upd && valid && (tag == wr_tag)) begin
      data  <= wr_word;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// 32-bit word access to 16-bit SRAM as two half accesses.
// Ports: clk, rst (async low), bus (slave), SRAM_* pins.
// Optional SRAM_RD_CACHE_EN adds a one-entry read cache.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          ADDR_W      = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  sram_controller_if.slave  bus,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N
);

  localparam int IDX_W = ADDR_W - 1;
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES);

  state_t state, state_n;
  op_t    op;
  logic [3:0]       cnt, cnt_n;
  logic [IDX_W-1:0] widx;
  logic [31:0]      wdata;
  logic [31:0]      rd_q;

  logic [31:0]      off;
  logic [IDX_W-1:0] req_idx;
  logic             req;
  logic             hit;
  logic             start;
  logic             phase_end;
  logic             ready_c;
  logic             we_n;
  logic             oe_n;
  logic             drive;
  logic [15:0]      dq_o;
  logic             unused;

  // word index wraps modulo 2^32 below BASE_ADDR
  assign off     = bus.addr - BASE_ADDR;
  assign req_idx = off[ADDR_W:2];
  assign unused  = ^{off[1:0], off[31:ADDR_W+1]};

  assign req       = bus.rd_en | bus.wr_en;
  assign phase_end = (cnt == LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && !hit) begin
          state_n = LO;
          cnt_n   = '0;
          start   = 1'b1;
        end
      end
      LO: begin
        if (phase_end) begin
          state_n = HI;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      HI: begin
        if (phase_end) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // WE_N rises in the last cycle of a write phase so the
  // address and data are stable around the rising strobe
  always_comb begin
    ready_c = 1'b0;
    we_n    = 1'b1;
    oe_n    = 1'b1;
    drive   = 1'b0;
    dq_o    = wdata[15:0];
    unique case (state)
      IDLE: ready_c = ~req | hit;
      LO, HI: begin
        if (op == OP_WR) begin
          drive = 1'b1;
          we_n  = phase_end;
        end else begin
          oe_n = 1'b0;
        end
      end
      DONE: ready_c = 1'b1;
      default: ready_c = 1'b0;
    endcase
    if (state == HI) begin
      dq_o = wdata[31:16];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= OP_RD;
      widx  <= '0;
      wdata <= '0;
      rd_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (start) begin
        op    <= bus.wr_en ? OP_WR : OP_RD;
        widx  <= req_idx;
        wdata <= bus.wr_data;
      end
      if ((op == OP_RD) && phase_end) begin
        if (state == LO) rd_q[15:0]  <= SRAM_DQ;
        if (state == HI) rd_q[31:16] <= SRAM_DQ;
      end
    end
  end

  assign SRAM_DQ   = drive ? dq_o : 16'hzzzz;
  assign SRAM_ADDR = {widx, (state == HI) ? HALF_HI : HALF_LO};
  assign SRAM_WE_N = we_n;
  assign SRAM_OE_N = oe_n;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign bus.ready = ready_c;

`ifdef SRAM_RD_CACHE_EN
  logic        c_hit;
  logic [31:0] c_data;

  sram_rd_cache #(
    .TAG_W (IDX_W)
  ) u_cache (
    .clk      (clk),
    .rst      (rst),
    .look_tag (req_idx),
    .hit      (c_hit),
    .hit_data (c_data),
    .fill     ((state == DONE) && (op == OP_RD)),
    .upd      ((state == DONE) && (op == OP_WR)),
    .wr_tag   (widx),
    .wr_word  ((op == OP_WR) ? wdata : rd_q)
  );

  // a hit only counts for a pure read seen in IDLE
  assign hit = (state == IDLE) && bus.rd_en &&
               !bus.wr_en && c_hit;
  assign bus.rd_data = hit ? c_data : rd_q;
`else
  assign hit = 1'b0;
  assign bus.rd_data = rd_q;
`endif

endmodule
